// File: rtl/vram_pixel_writer_pkg.sv
// Shared widths, packer state encoding and the word-address helper for the
// pixel-pair VRAM writer.
package vram_pixel_writer_pkg;

   localparam int PIXEL_W     = 18;
   localparam int VRAM_DATA_W = 36;
   localparam int VRAM_ADDR_W = 19;
   localparam int HCOUNT_W    = 11;
   localparam int VCOUNT_W    = 10;

   typedef enum logic {
      PK_EMPTY = 1'b0,
      PK_HALF  = 1'b1
   } packer_state_t;

   // Two horizontally adjacent pixels share one word: {row, column / 2}.
   function automatic logic [VRAM_ADDR_W-1:0] pack_addr(
      input logic [VCOUNT_W-1:0] y,
      input logic [HCOUNT_W-1:0] x
   );
      return {y, x[HCOUNT_W-2:1]};
   endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Packed-word queue between the pixel packer and the VRAM write port.
// Read data is registered, so a pop shows up on the outputs one edge later.
module vram_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 55
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_req,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same edge, so a push into a full queue survives.
   assign do_pop  = pop_req && (count != '0);
   assign do_push = push && ((count != FULL_COUNT) || do_pop);

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (do_pop) begin
         rd_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count    <= count_next;
         empty    <= (count_next == '0);
         rd_valid <= do_pop;
         if (push && !do_push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_pixel_writer.sv
// Pairs even/odd pixels into 36-bit VRAM words and issues them through a
// small queue whenever the arbiter grants a write slot.
module vram_pixel_writer
   import vram_pixel_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pix_valid,
   input  logic [HCOUNT_W-1:0]    pix_x,
   input  logic [VCOUNT_W-1:0]    pix_y,
   input  logic [PIXEL_W-1:0]     pix_data,
   input  logic                   write_slot,
   output logic [VRAM_ADDR_W-1:0] vram_addr,
   output logic [VRAM_DATA_W-1:0] vram_write_data,
   output logic                   vram_we,
   output logic                   fifo_empty,
   output logic                   overflow,
   output logic [DROP_CNT_W-1:0]  drop_count
);
   localparam int ENTRY_W = VRAM_ADDR_W + VRAM_DATA_W;

   packer_state_t          state;
   logic [VRAM_ADDR_W-1:0] hold_addr;
   logic [PIXEL_W-1:0]     hold_data;

   logic                   pix_ok;
   logic                   is_odd;
   logic [VRAM_ADDR_W-1:0] pix_addr;
   logic                   pair_match;
   logic                   push;
   logic [ENTRY_W-1:0]     push_word;
   logic [1:0]             drop_inc;
   logic [DROP_CNT_W:0]    drop_sum;
   logic [DROP_CNT_W-1:0]  drop_next;
   logic                   rd_valid;
   logic [ENTRY_W-1:0]     rd_data;

   // Columns with bit 10 set lie outside the 1024-wide frame.
   assign pix_ok     = pix_valid && !pix_x[HCOUNT_W-1];
   assign is_odd     = pix_x[0];
   assign pix_addr   = pack_addr(pix_y, pix_x);
   assign pair_match = (hold_addr == pix_addr);
   assign push       = pix_ok && (state == PK_HALF) && is_odd && pair_match;
   assign push_word  = {hold_addr, hold_data, pix_data};

   always_comb begin
      drop_inc = 2'd0;
      if (pix_ok) begin
         if (state == PK_EMPTY) begin
            drop_inc = is_odd ? 2'd1 : 2'd0;
         end else if (!is_odd) begin
            drop_inc = 2'd1;
         end else if (!pair_match) begin
            drop_inc = 2'd2;
         end
      end
   end

   assign drop_sum  = {1'b0, drop_count} + {{(DROP_CNT_W-1){1'b0}}, drop_inc};
   assign drop_next = drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PK_EMPTY;
         hold_addr  <= '0;
         hold_data  <= '0;
         drop_count <= '0;
      end else if (pix_ok) begin
         drop_count <= drop_next;
         case (state)
            PK_EMPTY: begin
               if (!is_odd) begin
                  state     <= PK_HALF;
                  hold_addr <= pix_addr;
                  hold_data <= pix_data;
               end
            end
            PK_HALF: begin
               // A fresh even pixel replaces the held one; any odd pixel closes the pair.
               if (!is_odd) begin
                  hold_addr <= pix_addr;
                  hold_data <= pix_data;
               end else begin
                  state <= PK_EMPTY;
               end
            end
            default: state <= PK_EMPTY;
         endcase
      end
   end

   vram_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_word),
      .pop_req   (write_slot),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

   assign vram_we         = rd_valid;
   assign vram_addr       = rd_data[ENTRY_W-1 -: VRAM_ADDR_W];
   assign vram_write_data = rd_data[VRAM_DATA_W-1:0];

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Directed bench for vram_pixel_writer: pairing, ordering, overflow, drops,
// reset behaviour and counter saturation.
module tb_vram_pixel_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [17:0] pix_data;
   logic        write_slot;
   logic [18:0] vram_addr;
   logic [35:0] vram_write_data;
   logic        vram_we;
   logic        fifo_empty;
   logic        overflow;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [18:0] wq_addr[$];
   logic [35:0] wq_data[$];

   always #5 clk = ~clk;

   vram_pixel_writer #(
      .FIFO_DEPTH (4),
      .DROP_CNT_W (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pix_valid       (pix_valid),
      .pix_x           (pix_x),
      .pix_y           (pix_y),
      .pix_data        (pix_data),
      .write_slot      (write_slot),
      .vram_addr       (vram_addr),
      .vram_write_data (vram_write_data),
      .vram_we         (vram_we),
      .fifo_empty      (fifo_empty),
      .overflow        (overflow),
      .drop_count      (drop_count)
   );

   always @(negedge clk) begin
      if (vram_we === 1'b1) begin
         wq_addr.push_back(vram_addr);
         wq_data.push_back(vram_write_data);
         $display("write addr=%05h data=%09h", vram_addr, vram_write_data);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pix(input logic [10:0] x, input logic [9:0] y, input logic [17:0] d);
      pix_valid = 1'b1;
      pix_x     = x;
      pix_y     = y;
      pix_data  = d;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(3);
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", vram_we); end
      n_cmp++; if (vram_addr !== 19'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", vram_addr); end
      n_cmp++; if (vram_write_data !== 36'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", vram_write_data); end
      n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", fifo_empty); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
      n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_basic_pair();
      write_slot = 1'b1;
      clear_q();
      send_pix(11'd0, 10'd0, 18'h3F03F);
      send_pix(11'd1, 10'd0, 18'h00FC0);
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL basic_no_bypass got=%b want=0", vram_we); end
      n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL basic_empty_after_push got=%b want=0", fifo_empty); end
      step(1);
      n_cmp++; if (vram_we !== 1'b1) begin n_bad++; $display("FAIL basic_we got=%b want=1", vram_we); end
      n_cmp++; if (vram_addr !== 19'h0) begin n_bad++; $display("FAIL basic_addr got=%h want=0", vram_addr); end
      n_cmp++; if (vram_write_data !== 36'hFC0FC0FC0) begin n_bad++; $display("FAIL basic_data got=%h want=FC0FC0FC0", vram_write_data); end
      n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty_after_pop got=%b want=1", fifo_empty); end
      step(1);
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL basic_we_one_cycle got=%b want=0", vram_we); end
      n_cmp++; if (vram_write_data !== 36'hFC0FC0FC0) begin n_bad++; $display("FAIL basic_data_hold got=%h want=FC0FC0FC0", vram_write_data); end
      n_cmp++; if (wq_addr.size() !== 1) begin n_bad++; $display("FAIL basic_count got=%0d want=1", wq_addr.size()); end
   endtask

   task automatic test_row_wrap_and_ignore();
      logic [18:0] exp_a [3];
      logic [35:0] exp_d [3];
      logic [18:0] ga;
      logic [35:0] gd;
      exp_a[0] = 19'h00BFF; exp_d[0] = 36'h000040002;
      exp_a[1] = 19'h00C00; exp_d[1] = 36'hFFFFC0000;
      exp_a[2] = 19'h00001; exp_d[2] = 36'h48D145555;
      write_slot = 1'b1;
      clear_q();
      send_pix(11'd1022, 10'd5, 18'h00001);
      send_pix(11'd1023, 10'd5, 18'h00002);
      send_pix(11'd0,    10'd6, 18'h3FFFF);
      send_pix(11'd1,    10'd6, 18'h00000);
      send_pix(11'd2,    10'd0, 18'h12345);
      send_pix(11'd1027, 10'd0, 18'h3AAAA);
      send_pix(11'd3,    10'd0, 18'h05555);
      step(4);
      n_cmp++; if (wq_addr.size() !== 3) begin n_bad++; $display("FAIL wrap_count got=%0d want=3", wq_addr.size()); end
      for (int i = 0; i < 3; i++) begin
         ga = (i < wq_addr.size()) ? wq_addr[i] : 'x;
         gd = (i < wq_data.size()) ? wq_data[i] : 'x;
         n_cmp++; if (ga !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, ga, exp_a[i]); end
         n_cmp++; if (gd !== exp_d[i]) begin n_bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, gd, exp_d[i]); end
      end
      n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL ignore_drop got=%0d want=0", drop_count); end
   endtask

   task automatic test_overflow();
      logic [18:0] ga;
      write_slot = 1'b0;
      clear_q();
      for (int k = 0; k < 5; k++) begin
         send_pix(11'd0, 10'(10 + k), 18'(10 + k));
         send_pix(11'd1, 10'(10 + k), 18'(16'h100 + 10 + k));
         if (k == 3) begin
            n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_full got=%b want=0", overflow); end
         end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
      n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b want=0", fifo_empty); end
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL ovf_no_write got=%b want=0", vram_we); end
      write_slot = 1'b1;
      step(8);
      n_cmp++; if (wq_addr.size() !== 4) begin n_bad++; $display("FAIL ovf_count got=%0d want=4", wq_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         ga = (i < wq_addr.size()) ? wq_addr[i] : 'x;
         n_cmp++; if (ga !== 19'((10 + i) << 9)) begin n_bad++; $display("FAIL ovf_addr[%0d] got=%h want=%h", i, ga, 19'((10 + i) << 9)); end
      end
      n_cmp++; if ((wq_data.size() > 0 ? wq_data[0] : 36'hx) !== 36'h00028010A) begin n_bad++; $display("FAIL ovf_data0 got=%h want=00028010A", wq_data.size() > 0 ? wq_data[0] : 36'hx); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
      n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained got=%b want=1", fifo_empty); end
   endtask

   task automatic test_drop();
      write_slot = 1'b1;
      clear_q();
      send_pix(11'd2, 10'd0, 18'h00002);
      send_pix(11'd4, 10'd0, 18'h00004);
      n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL drop_even_replace got=%0d want=1", drop_count); end
      send_pix(11'd5, 10'd0, 18'h00005);
      send_pix(11'd9, 10'd0, 18'h00009);
      n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL drop_orphan got=%0d want=2", drop_count); end
      step(3);
      n_cmp++; if (wq_addr.size() !== 1) begin n_bad++; $display("FAIL drop_count_writes got=%0d want=1", wq_addr.size()); end
      n_cmp++; if ((wq_addr.size() > 0 ? wq_addr[0] : 19'hx) !== 19'h2) begin n_bad++; $display("FAIL drop_addr got=%h want=2", wq_addr.size() > 0 ? wq_addr[0] : 19'hx); end
      n_cmp++; if ((wq_data.size() > 0 ? wq_data[0] : 36'hx) !== 36'h000100005) begin n_bad++; $display("FAIL drop_data got=%h want=000100005", wq_data.size() > 0 ? wq_data[0] : 36'hx); end
      send_pix(11'd6, 10'd0, 18'h00006);
      send_pix(11'd9, 10'd0, 18'h00009);
      step(3);
      n_cmp++; if (drop_count !== 8'd4) begin n_bad++; $display("FAIL drop_mismatch got=%0d want=4", drop_count); end
      n_cmp++; if (wq_addr.size() !== 1) begin n_bad++; $display("FAIL drop_mismatch_writes got=%0d want=1", wq_addr.size()); end
   endtask

   task automatic test_reset_mid();
      write_slot = 1'b0;
      send_pix(11'd0, 10'd20, 18'h00AAA);
      send_pix(11'd1, 10'd20, 18'h00BBB);
      send_pix(11'd0, 10'd21, 18'h00CCC);
      send_pix(11'd1, 10'd21, 18'h00DDD);
      send_pix(11'd0, 10'd22, 18'h00EEE);
      n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL mid_queued got=%b want=0", fifo_empty); end
      reset = 1'b1;
      #2;
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL mid_we got=%b want=0", vram_we); end
      n_cmp++; if (vram_addr !== 19'h0) begin n_bad++; $display("FAIL mid_addr got=%h want=0", vram_addr); end
      n_cmp++; if (vram_write_data !== 36'h0) begin n_bad++; $display("FAIL mid_data got=%h want=0", vram_write_data); end
      n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty got=%b want=1", fifo_empty); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_overflow got=%b want=0", overflow); end
      n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL mid_drop got=%0d want=0", drop_count); end
      step(1);
      reset = 1'b0;
      write_slot = 1'b1;
      clear_q();
      step(5);
      n_cmp++; if (wq_addr.size() !== 0) begin n_bad++; $display("FAIL mid_no_write got=%0d want=0", wq_addr.size()); end
      send_pix(11'd1, 10'd22, 18'h00FFF);
      step(3);
      n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL mid_orphan got=%0d want=1", drop_count); end
      n_cmp++; if (wq_addr.size() !== 0) begin n_bad++; $display("FAIL mid_orphan_write got=%0d want=0", wq_addr.size()); end
      send_pix(11'd2, 10'd22, 18'h00011);
      send_pix(11'd3, 10'd22, 18'h00022);
      step(3);
      n_cmp++; if (wq_addr.size() !== 1) begin n_bad++; $display("FAIL mid_new_pair got=%0d want=1", wq_addr.size()); end
      n_cmp++; if ((wq_addr.size() > 0 ? wq_addr[0] : 19'hx) !== 19'h02C01) begin n_bad++; $display("FAIL mid_new_addr got=%h want=02C01", wq_addr.size() > 0 ? wq_addr[0] : 19'hx); end
   endtask

   task automatic test_saturate();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      clear_q();
      pix_valid = 1'b1;
      pix_x     = 11'd1;
      pix_y     = 10'd0;
      pix_data  = 18'h00001;
      for (int i = 1; i <= 260; i++) begin
         step(1);
         if (i == 100) begin
            n_cmp++; if (drop_count !== 8'd100) begin n_bad++; $display("FAIL sat_mid got=%0d want=100", drop_count); end
         end
      end
      pix_valid = 1'b0;
      n_cmp++; if (drop_count !== 8'd255) begin n_bad++; $display("FAIL sat_max got=%0d want=255", drop_count); end
      send_pix(11'd6, 10'd0, 18'h00006);
      send_pix(11'd9, 10'd0, 18'h00009);
      step(3);
      n_cmp++; if (drop_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold got=%0d want=255", drop_count); end
      n_cmp++; if (wq_addr.size() !== 0) begin n_bad++; $display("FAIL sat_no_write got=%0d want=0", wq_addr.size()); end
   endtask

   initial begin
      reset      = 1'b1;
      pix_valid  = 1'b0;
      pix_x      = '0;
      pix_y      = '0;
      pix_data   = '0;
      write_slot = 1'b0;
      test_reset();
      test_basic_pair();
      test_row_wrap_and_ignore();
      test_overflow();
      test_drop();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
